// File: rtl/loader_pkg.sv
// Shared types and widths for the UART program loader.
package loader_pkg;

  localparam int unsigned ADR_W  = 14;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {LEN0, LEN1, DATA, DONE} ld_state_e;

  typedef enum logic [1:0] {IDLE, START, BITS, STOP} rx_state_e;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Instruction-ROM programming port driven by the loader.
interface uart_prog_loader_if;
  import loader_pkg::*;

  logic              upg_wen;
  logic [ADR_W-1:0]  upg_adr;
  logic [WORD_W-1:0] upg_dat;
  logic              upg_done;

  modport master (output upg_wen, output upg_adr, output upg_dat, output upg_done);
  modport slave  (input upg_wen, input upg_adr, input upg_dat, input upg_done);

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchronizer, mid-bit sampling, stop-bit check.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e       state_q, state_d;
  logic [1:0]      sync_q;
  logic            prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx_s;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Edge-triggered so a line still low after a bad stop bit is not a start.
        if (prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HalfCnt) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : BITS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BITS: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          valid_d = rx_s;
          err_d   = !rx_s;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a length-prefixed little-endian word image from UART into instruction memory.
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned MAX_WORDS    = 16384
) (
  input  logic                      upg_clk_i,
  input  logic                      upg_rst_i,
  input  logic                      rx_i,
  uart_prog_loader_if.master        upg,
  output logic                      frame_err_o
);

  localparam logic [15:0] MaxN = 16'(MAX_WORDS);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk_i        (upg_clk_i),
    .rst_i        (upg_rst_i),
    .rx_i         (rx_i),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_err)
  );

  ld_state_e         state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [14:0]       idx_q, idx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       word_q, word_d;
  logic              wen_q, wen_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [WORD_W-1:0] dat_q, dat_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic [15:0]       len_raw;
  logic [14:0]       idx_inc;

  assign len_raw = {rx_byte, len_lo_q};
  assign idx_inc = idx_q + 15'd1;

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      state_q  <= LEN0;
      len_lo_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      word_q   <= '0;
      wen_q    <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      word_q   <= word_d;
      wen_q    <= wen_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      done_q   <= done_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    word_d   = word_q;
    wen_d    = 1'b0;
    adr_d    = adr_q;
    dat_d    = dat_q;
    // Done follows the DONE state by one cycle, after the last strobe.
    done_d   = done_q | (state_q == DONE);
    ferr_d   = ferr_q | rx_err;
    if (rx_valid) begin
      unique case (state_q)
        LEN0: begin
          len_lo_d = rx_byte;
          state_d  = LEN1;
        end
        LEN1: begin
          len_d   = (len_raw > MaxN) ? MaxN : len_raw;
          state_d = (len_raw == 16'd0) ? DONE : DATA;
        end
        DATA: begin
          bcnt_d = bcnt_q + 2'd1;
          word_d = {rx_byte, word_q[23:8]};
          if (bcnt_q == 2'd3) begin
            wen_d = 1'b1;
            adr_d = idx_q[ADR_W-1:0];
            dat_d = {rx_byte, word_q};
            idx_d = idx_inc;
            if ({1'b0, idx_inc} == len_q) state_d = DONE;
          end
        end
        DONE: ;
        default: state_d = LEN0;
      endcase
    end
  end

  assign upg.upg_wen  = wen_q;
  assign upg.upg_adr  = adr_q;
  assign upg.upg_dat  = dat_q;
  assign upg.upg_done = done_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with CLKS_PER_BIT = 4.
module tb_uart_prog_loader;
  import loader_pkg::*;

  localparam int unsigned Cpb = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic ferr;

  uart_prog_loader_if upg_if ();

  uart_prog_loader #(
    .CLKS_PER_BIT (Cpb),
    .MAX_WORDS    (16384)
  ) dut (
    .upg_clk_i   (clk),
    .upg_rst_i   (rst),
    .rx_i        (rx),
    .upg         (upg_if.master),
    .frame_err_o (ferr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Write log and event timing, observed on the falling edge.
  logic [13:0] wr_adr [0:63];
  logic [31:0] wr_dat [0:63];
  int n_wr = 0;
  int wen_cyc = 0;
  int done_cyc = 0;
  bit done_seen = 0;
  int bv_cnt = 0;
  int bv_cyc = 0;
  int bad_wen = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (upg_if.upg_wen) begin
      if (rst || done_prev) bad_wen = bad_wen + 1;
      if (n_wr < 64) begin
        wr_adr[n_wr] = upg_if.upg_adr;
        wr_dat[n_wr] = upg_if.upg_dat;
      end
      n_wr    = n_wr + 1;
      wen_cyc = cyc;
    end
    if (dut.u_rx.byte_valid_o) begin
      bv_cnt = bv_cnt + 1;
      bv_cyc = cyc;
    end
    if (rst) done_seen = 0;
    else if (upg_if.upg_done && !done_seen) begin
      done_seen = 1;
      done_cyc  = cyc;
    end
    done_prev = upg_if.upg_done;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    assert (got === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int idle);
    rx = 1'b0;
    wait_cyc(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(Cpb);
    end
    rx = stop;
    wait_cyc(Cpb);
    rx = 1'b1;
    if (idle > 0) wait_cyc(idle);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
  endtask

  int base;
  int bv0;

  initial begin
    // Reset held with rx toggling.
    rst = 1'b1;
    wait_cyc(1);
    for (int i = 0; i < 40; i++) begin
      rx = ~rx;
      wait_cyc(1 + (i % 3));
    end
    rx = 1'b1;
    wait_cyc(2);
    check("rst_wen", {31'd0, upg_if.upg_wen}, 32'd0);
    check("rst_adr", {18'd0, upg_if.upg_adr}, 32'd0);
    check("rst_dat", upg_if.upg_dat, 32'd0);
    check("rst_done", {31'd0, upg_if.upg_done}, 32'd0);
    check("rst_ferr", {31'd0, ferr}, 32'd0);
    check("rst_no_byte", bv_cnt, 0);
    rst = 1'b0;
    wait_cyc(4);

    // Two-word image, back-to-back bytes.
    base = n_wr;
    bv0  = bv_cnt;
    send_byte(8'h02, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'h13, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'hB3, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'h50, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    wait_cyc(20);
    check("two_bytes", bv_cnt - bv0, 10);
    check("two_nwr", n_wr - base, 2);
    check("two_adr0", {18'd0, wr_adr[base]}, 32'd0);
    check("two_dat0", wr_dat[base], 32'h0000_0013);
    check("two_adr1", {18'd0, wr_adr[base+1]}, 32'd1);
    check("two_dat1", wr_dat[base+1], 32'h0050_00B3);
    check("two_done", {31'd0, upg_if.upg_done}, 32'd1);
    check("two_done_lat", done_cyc - wen_cyc, 1);
    check("two_ferr", {31'd0, ferr}, 32'd0);
    check("two_adr_hold", {18'd0, upg_if.upg_adr}, 32'd1);
    check("two_dat_hold", upg_if.upg_dat, 32'h0050_00B3);

    // Empty image and ignored trailing bytes.
    do_reset();
    base = n_wr;
    send_byte(8'h00, 1'b1, 4);
    send_byte(8'h00, 1'b1, 4);
    wait_cyc(10);
    check("empty_done", {31'd0, upg_if.upg_done}, 32'd1);
    check("empty_done_lat", done_cyc - bv_cyc, 2);
    send_byte(8'h11, 1'b1, 4);
    send_byte(8'h22, 1'b1, 4);
    send_byte(8'h33, 1'b1, 4);
    send_byte(8'h44, 1'b1, 4);
    wait_cyc(10);
    check("empty_nwr", n_wr - base, 0);
    check("empty_done_hold", {31'd0, upg_if.upg_done}, 32'd1);

    // Glitch rejection, then a one-word image with one bad stop bit.
    do_reset();
    base = n_wr;
    bv0  = bv_cnt;
    rx = 1'b0;
    wait_cyc(1);
    rx = 1'b1;
    wait_cyc(60);
    check("glitch_no_byte", bv_cnt - bv0, 0);
    check("glitch_ferr", {31'd0, ferr}, 32'd0);
    send_byte(8'h01, 1'b1, 4);
    send_byte(8'h00, 1'b1, 4);
    send_byte(8'h11, 1'b1, 4);
    send_byte(8'h99, 1'b0, 8);
    send_byte(8'h22, 1'b1, 4);
    send_byte(8'h33, 1'b1, 4);
    send_byte(8'h44, 1'b1, 4);
    wait_cyc(10);
    check("ferr_sticky", {31'd0, ferr}, 32'd1);
    check("ferr_nwr", n_wr - base, 1);
    check("ferr_adr", {18'd0, wr_adr[base]}, 32'd0);
    check("ferr_dat", wr_dat[base], 32'h4433_2211);
    check("ferr_done", {31'd0, upg_if.upg_done}, 32'd1);

    // Reset mid-word discards the partial word.
    do_reset();
    check("rst_clears_ferr", {31'd0, ferr}, 32'd0);
    base = n_wr;
    send_byte(8'h01, 1'b1, 4);
    send_byte(8'h00, 1'b1, 4);
    send_byte(8'hAA, 1'b1, 4);
    send_byte(8'hBB, 1'b1, 4);
    do_reset();
    send_byte(8'h01, 1'b1, 4);
    send_byte(8'h00, 1'b1, 4);
    send_byte(8'hDE, 1'b1, 4);
    send_byte(8'hAD, 1'b1, 4);
    send_byte(8'hBE, 1'b1, 4);
    send_byte(8'hEF, 1'b1, 4);
    wait_cyc(10);
    check("mid_nwr", n_wr - base, 1);
    check("mid_adr", {18'd0, wr_adr[base]}, 32'd0);
    check("mid_dat", wr_dat[base], 32'hEFBE_ADDE);
    check("mid_done", {31'd0, upg_if.upg_done}, 32'd1);
    check("no_wen_rst_or_done", bad_wen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
